// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts rising edges of spike_in over fixed windows and
// publishes a saturating count with saturation and burst flags at each window end.
module spike_rate_monitor #(
  parameter int unsigned WINDOW_LEN = 1000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [CNT_W-1:0] burst_thresh,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic             rate_burst,
  output logic [7:0]       window_idx
);

  localparam int unsigned      WIN_W   = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] LAST    = WIN_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_d;
  logic             spike_prev;
  logic             spike_edge;
  logic [WIN_W-1:0] win_cnt, win_cnt_d;
  logic [CNT_W-1:0] acc, acc_d;
  logic             sat_acc, sat_acc_d;
  logic [CNT_W:0]   sum_c;
  logic [CNT_W-1:0] fin_c;
  logic             sat_fin_c;
  logic [CNT_W-1:0] rate_count_d;
  logic             rate_valid_d, rate_sat_d, rate_burst_d;
  logic [7:0]       window_idx_d;

  assign spike_edge = spike_in & ~spike_prev;

  // Window-end result: the final cycle's edge can still push the count into saturation.
  always_comb begin
    sum_c     = {1'b0, acc} + (CNT_W + 1)'(spike_edge);
    fin_c     = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
    sat_fin_c = sum_c[CNT_W] | sat_acc;
  end

  always_comb begin
    state_d      = state;
    win_cnt_d    = win_cnt;
    acc_d        = acc;
    sat_acc_d    = sat_acc;
    rate_count_d = rate_count;
    rate_valid_d = 1'b0;
    rate_sat_d   = rate_sat;
    rate_burst_d = rate_burst;
    window_idx_d = window_idx;
    case (state)
      IDLE: begin
        win_cnt_d = '0;
        acc_d     = '0;
        sat_acc_d = 1'b0;
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d   = IDLE;
          win_cnt_d = '0;
          acc_d     = '0;
          sat_acc_d = 1'b0;
        end else if (win_cnt == LAST) begin
          rate_count_d = fin_c;
          rate_sat_d   = sat_fin_c;
          rate_burst_d = (fin_c >= burst_thresh);
          rate_valid_d = 1'b1;
          window_idx_d = window_idx + 8'd1;
          win_cnt_d    = '0;
          acc_d        = '0;
          sat_acc_d    = 1'b0;
        end else begin
          win_cnt_d = win_cnt + WIN_W'(1);
          if (spike_edge) begin
            if (acc == CNT_MAX) sat_acc_d = 1'b1;
            else                acc_d     = acc + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      spike_prev <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      sat_acc    <= 1'b0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
      rate_burst <= 1'b0;
      window_idx <= '0;
    end else begin
      state      <= state_d;
      spike_prev <= spike_in;
      win_cnt    <= win_cnt_d;
      acc        <= acc_d;
      sat_acc    <= sat_acc_d;
      rate_count <= rate_count_d;
      rate_valid <= rate_valid_d;
      rate_sat   <= rate_sat_d;
      rate_burst <= rate_burst_d;
      window_idx <= window_idx_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: two instances (16-cycle/8-bit and 64-cycle/4-bit)
// checked every cycle against a window-level reference model.
module tb_spike_rate_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] bt_a = 8'd4;
  logic [3:0] bt_b = 4'd10;
  logic [7:0] cnt_a, idx_a, idx_b;
  logic [3:0] cnt_b;
  logic       val_a, sat_a, bur_a, val_b, sat_b, bur_b;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  spike_rate_monitor #(.WINDOW_LEN(16), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .burst_thresh(bt_a), .rate_count(cnt_a), .rate_valid(val_a),
    .rate_sat(sat_a), .rate_burst(bur_a), .window_idx(idx_a)
  );

  spike_rate_monitor #(.WINDOW_LEN(64), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .burst_thresh(bt_b), .rate_count(cnt_b), .rate_valid(val_b),
    .rate_sat(sat_b), .rate_burst(bur_b), .window_idx(idx_b)
  );

  // Reference model: counts raw edges per window, then clamps once at window end.
  localparam int WIN  [2] = '{16, 64};
  localparam int MAXV [2] = '{255, 15};
  bit m_act [2] = '{0, 0};
  int m_pos [2] = '{0, 0};
  int m_edg [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_val [2] = '{0, 0};
  bit m_sat [2] = '{0, 0};
  bit m_bur [2] = '{0, 0};
  int m_idx [2] = '{0, 0};
  bit m_prev = 1'b0;
  int m_thr;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 0; m_pos[i] = 0; m_edg[i] = 0; m_cnt[i] = 0;
        m_val[i] = 0; m_sat[i] = 0; m_bur[i] = 0; m_idx[i] = 0;
      end else begin
        m_val[i] = 0;
        if (!m_act[i]) begin
          if (enable) begin m_act[i] = 1; m_pos[i] = 0; m_edg[i] = 0; end
        end else if (!enable) begin
          m_act[i] = 0;
        end else begin
          if (spike_in && !m_prev) m_edg[i]++;
          m_pos[i]++;
          if (m_pos[i] == WIN[i]) begin
            m_thr    = (i == 0) ? int'(bt_a) : int'(bt_b);
            m_cnt[i] = (m_edg[i] > MAXV[i]) ? MAXV[i] : m_edg[i];
            m_sat[i] = (m_edg[i] > MAXV[i]);
            m_bur[i] = (m_cnt[i] >= m_thr);
            m_val[i] = 1;
            m_idx[i] = (m_idx[i] + 1) % 256;
            m_pos[i] = 0;
            m_edg[i] = 0;
          end
        end
      end
    end
    m_prev = reset ? 1'b0 : spike_in;
  end

  logic [33:0] obs, expv;
  assign obs = {cnt_a, val_a, sat_a, bur_a, idx_a, cnt_b, val_b, sat_b, bur_b, idx_b};
  always_comb expv = {8'(m_cnt[0]), m_val[0], m_sat[0], m_bur[0], 8'(m_idx[0]),
                      4'(m_cnt[1]), m_val[1], m_sat[1], m_bur[1], 8'(m_idx[1])};

  task automatic cyc(input bit e, input bit s);
    enable   = e;
    spike_in = s;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic restart();
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b1, k[0]);
    total++;
    if (obs !== 34'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)));
      total++;
      if (obs !== 34'd0 || obs !== expv) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h want=0", cyc_n, obs);
      end
    end
  endtask

  task automatic test_basic();
    bt_a = 8'd4;
    restart();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, (k == 1 || k == 4 || k == 7 || k == 10 || k == 13));
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL basic_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
    end
    total++;
    if ({cnt_a, val_a, sat_a, bur_a, idx_a} !== {8'd5, 1'b1, 1'b0, 1'b1, 8'd1}) begin
      bad++; $display("FAIL basic_result got=%h want=%h",
                      {cnt_a, val_a, sat_a, bur_a, idx_a}, {8'd5, 1'b1, 1'b0, 1'b1, 8'd1});
    end
    cyc(1'b1, 1'b0);
    total++;
    if (val_a !== 1'b0) begin
      bad++; $display("FAIL basic_valid_width got=%b want=0", val_a);
    end
  endtask

  task automatic test_level();
    restart();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, (k < 10) || (k == 11));
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL level_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
    end
    total++;
    if ({cnt_a, val_a, idx_a} !== {8'd2, 1'b1, 8'd2}) begin
      bad++; $display("FAIL level_count got=%h want=%h", {cnt_a, val_a, idx_a}, {8'd2, 1'b1, 8'd2});
    end
  endtask

  task automatic test_saturation();
    bt_b = 4'd10;
    restart();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 64; k++) begin
        if (w == 0) cyc(1'b1, (k < 40) && (k % 2 == 0));
        else        cyc(1'b1, (k == 5 || k == 20 || k == 40));
        total++;
        if (obs !== expv) begin
          bad++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
        end
      end
      total++;
      if (w == 0 && {cnt_b, val_b, sat_b, bur_b} !== {4'd15, 1'b1, 1'b1, 1'b1}) begin
        bad++; $display("FAIL sat_win1 got=%h want=%h", {cnt_b, val_b, sat_b, bur_b}, {4'd15, 3'b111});
      end
      if (w == 1 && {cnt_b, val_b, sat_b, bur_b} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
        bad++; $display("FAIL sat_win2 got=%h want=%h", {cnt_b, val_b, sat_b, bur_b}, {4'd3, 3'b100});
      end
    end
  endtask

  task automatic test_boundary();
    int vq[$];
    restart();
    for (int k = 0; k < 48; k++) begin
      cyc(1'b1, (k == 15 || k == 17 || k == 32));
      if (val_a) vq.push_back(cyc_n);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL boundary_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
      if (k % 16 == 15) begin
        total++;
        if ({cnt_a, val_a} !== {8'd1, 1'b1}) begin
          bad++; $display("FAIL boundary_count win=%0d got=%h want=%h", k / 16, {cnt_a, val_a}, {8'd1, 1'b1});
        end
      end
    end
    total++;
    if (vq.size() != 3) begin
      bad++; $display("FAIL boundary_pulses got=%0d want=3", vq.size());
    end else begin
      for (int j = 1; j < 3; j++) begin
        total++;
        if (vq[j] - vq[j-1] != 16) begin
          bad++; $display("FAIL boundary_spacing got=%0d want=16", vq[j] - vq[j-1]);
        end
      end
    end
  endtask

  task automatic test_abort();
    restart();
    for (int k = 0; k < 8; k++) cyc(1'b1, (k == 1 || k == 3 || k == 5));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (obs !== expv || val_a !== 1'b0 || cnt_a !== 8'd1) begin
        bad++; $display("FAIL abort_hold cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
    end
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, (k == 2 || k == 9));
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL abort_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
    end
    total++;
    if ({cnt_a, val_a} !== {8'd2, 1'b1}) begin
      bad++; $display("FAIL abort_recount got=%h want=%h", {cnt_a, val_a}, {8'd2, 1'b1});
    end
    restart();
    for (int k = 0; k < 8; k++) cyc(1'b1, (k == 1 || k == 3 || k == 5));
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    total++;
    if (obs !== 34'd0) begin
      bad++; $display("FAIL abort_reset got=%h want=0", obs);
    end
    cyc(1'b0, 1'b0);
    total++;
    if (obs !== 34'd0 || obs !== expv) begin
      bad++; $display("FAIL abort_reset_hold got=%h want=0", obs);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bt_a = 8'($urandom_range(0, 20));
        bt_b = 4'($urandom_range(0, 15));
      end
      cyc(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)));
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc_n, obs, expv);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_level();
    test_saturation();
    test_boundary();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
- Downstream consumer of the second synapse's spike output in the two-neuron chain.
- Counts rising edges of the spike line over fixed windows of WINDOW_LEN clock cycles.
- At each window end it latches a saturating spike count, a saturation flag and a burst flag, and pulses rate_valid for one cycle.
- Its results drive uo_out and the host readout in place of the current constant-zero outputs.

Parameters:
- WINDOW_LEN, 1000: window length in clock cycles; legal range 2..2^20.
- CNT_W, 8: width of the spike accumulator and rate_count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  high = monitoring active; connected to ena
- spike_in  input  1  spike line from the synapse output; may be high for more than one cycle
- burst_thresh  input  CNT_W  burst comparison threshold; sampled at window end
- rate_count  output  CNT_W  spike count of the last completed window
- rate_valid  output  1  one-cycle pulse when rate_count/rate_sat/rate_burst update
- rate_sat  output  1  the last completed window saturated
- rate_burst  output  1  last completed window count >= burst_thresh
- window_idx  output  8  number of completed windows, mod 256

Behaviour:
- Reset: when reset=1 at a clk edge, every register clears. After that edge rate_count=0, rate_valid=0, rate_sat=0, rate_burst=0 and window_idx=0. Internal state also clears: spike_prev=0, win_cnt=0, acc=0, sat_acc=0, state=IDLE. Reset has priority over all other inputs.
- Edge detect:
  - spike_prev <= spike_in every cycle, regardless of enable.
  - edge = spike_in & ~spike_prev (combinational, same cycle).
  - A level held high for N cycles counts as 1.
- FSM states: IDLE and COUNT.
  - IDLE: win_cnt=0, acc=0, sat_acc=0; outputs hold their last values. Go to COUNT when enable=1.
  - Entry into COUNT is registered. The first enabled cycle is spent in IDLE and is not counted.
  - The window starts on the cycle after enable is first sampled high.
- COUNT, enable=1, win_cnt < WINDOW_LEN-1:
  - win_cnt += 1.
  - If edge: if acc == 2^CNT_W-1 then sat_acc <= 1, else acc += 1.
- COUNT, enable=1, win_cnt == WINDOW_LEN-1 (window end):
  - final = acc + edge, saturating at 2^CNT_W-1. If the edge would overflow, final saturates and sat_final = 1; otherwise sat_final = sat_acc.
  - Next edge: rate_count <= final, rate_sat <= sat_final, rate_burst <= (final >= burst_thresh), rate_valid <= 1, window_idx += 1 (wraps 255 -> 0).
  - Also next edge: acc, sat_acc and win_cnt clear. Stay in COUNT; the next window starts immediately with no gap cycle.
- rate_valid is high for exactly one cycle per completed window. Otherwise it is 0.
- An edge on the last cycle of a window belongs to that window. An edge on the following cycle belongs to the next window.
- COUNT, enable=0:
  - Next edge goes to IDLE; the partial window is discarded.
  - No rate_valid pulse. Outputs hold. window_idx is not incremented.
- Reset mid-window: discards the partial window and clears all outputs.
- Latency: results are visible 1 cycle after the window's last cycle.
- burst_thresh=0: rate_burst=1 on every window.

Test Plan:
- Reset: assert reset 3 cycles with spike_in toggling -> all outputs 0. After release with enable=0, outputs stay 0 and no rate_valid.
- Basic count (WINDOW_LEN=16, CNT_W=8, burst_thresh=4): enable high; 5 one-cycle spikes spaced inside window 1 -> one cycle after the window's 16th cycle, rate_count=5, rate_valid=1 for 1 cycle, rate_burst=1, rate_sat=0, window_idx=1.
- Level vs edge: spike_in held high 10 cycles, then one 1-cycle pulse, in one window -> rate_count=2.
- Saturation (CNT_W=4, WINDOW_LEN=64): 20 pulses in window 1 -> rate_count=15, rate_sat=1. 3 pulses in window 2 -> rate_count=3, rate_sat=0.
- Boundary: pulse on the last cycle of window k and a new rising edge on the first cycle of window k+1 (spike_in low between) -> each window counts 1. Consecutive rate_valid pulses are exactly WINDOW_LEN cycles apart.
- Abort: enable dropped at win_cnt=8 after 3 spikes -> no rate_valid; outputs unchanged. Re-enable -> the next window counts from 0. Repeat with reset at win_cnt=8 -> outputs 0 and window_idx=0.
